rr_mux_arbiter: RTL and testbench

- Round-robin, packet-locking arbiter that shares one WIDTH-bit datapath among N_REQ requesters.
- Owns the select of the shared N:1 data mux. Per-requester valid/ready/last handshakes are funnelled onto a single valid/ready output stream.
- Sits in front of any single-consumer resource (bus port, FIFO, functional unit) that several masters feed.

---
 rtl/rr_mux_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_rr_mux_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
// Round-robin, packet-locking arbiter that owns the select of a shared N:1
// data mux. One requester at a time is granted the datapath and keeps it
// until its packet ends (req_last) or its beat quota runs out. Every grant
// goes through a one-cycle IDLE arbitration step. grant, out_sel and busy
// come straight from flops. The stream outputs are combinational views of
// the current owner's inputs.

module rr_mux_arbiter #(
    parameter int N_REQ     = 8,
    parameter int WIDTH     = 32,
    parameter int SEL_WIDTH = $clog2(N_REQ),
    parameter int MAX_BURST = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ-1:0]     req_last,
    input  logic [WIDTH-1:0]     req_data [0:N_REQ-1],
    output logic [N_REQ-1:0]     req_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    output logic [SEL_WIDTH-1:0] out_sel,
    input  logic                 out_ready,
    output logic [N_REQ-1:0]     grant,
    output logic                 busy
);

    // A quota of 0 means "unlimited". The counter then stays at zero and a
    // single bit is enough to keep the declarations legal.
    localparam bit QUOTA_EN = (MAX_BURST > 0);
    localparam int CNT_W    = QUOTA_EN ? $clog2(MAX_BURST + 1) : 1;

    // Count value on the final beat a grant may carry.
    localparam logic [CNT_W-1:0] CNT_LAST = QUOTA_EN ? CNT_W'(MAX_BURST - 1) : '0;

    // Highest requester index. The pointer wraps to 0 after this index.
    localparam logic [SEL_WIDTH-1:0] SEL_MAX = SEL_WIDTH'(N_REQ - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               state_q,    state_d;
    logic [SEL_WIDTH-1:0] ptr_q,      ptr_d;
    logic [SEL_WIDTH-1:0] owner_q,    owner_d;
    logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [N_REQ-1:0]     grant_q,    grant_d;
    logic                 busy_q,     busy_d;
    logic [SEL_WIDTH-1:0] sel_q,      sel_d;

    logic                 locked;
    logic                 owner_valid;
    logic                 owner_last;
    logic [WIDTH-1:0]     owner_data;
    logic                 quota_hit;
    logic                 transfer;
    logic                 release_pkt;
    logic                 win_found;
    logic [SEL_WIDTH-1:0] win_idx;
    logic [SEL_WIDTH-1:0] scan_idx;

    // Select the owner's request signals. This is the shared N:1 data mux.
    always_comb begin
        owner_valid = req_valid[owner_q];
        owner_last  = req_last[owner_q];
        owner_data  = req_data[owner_q];
    end

    // Decode the transfer, the quota and the release for the current beat.
    always_comb begin
        locked      = (state_q == LOCKED);
        quota_hit   = QUOTA_EN && (beat_cnt_q == CNT_LAST);
        transfer    = locked && owner_valid && out_ready;
        release_pkt = transfer && (owner_last || quota_hit);
    end

    // Rotating priority scan. The scan starts at ptr_q and wraps past
    // N_REQ-1, so the first valid requester found wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            scan_idx = SEL_WIDTH'((int'(ptr_q) + i) % N_REQ);
            if (!win_found && req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // Drive the shared stream and the per-requester ready.
    // Everything here is zero while no requester owns the datapath.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        req_ready = '0;
        if (locked) begin
            out_valid          = owner_valid;
            out_data           = owner_data;
            out_last           = owner_last | quota_hit;
            req_ready[owner_q] = out_ready;
        end
    end

    // Next-state logic for the arbitration FSM. The registered grant,
    // select and busy values are computed here too, so they change on the
    // same edge as the state.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        grant_d    = grant_q;
        busy_d     = busy_q;
        sel_d      = sel_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d          = LOCKED;
                    owner_d          = win_idx;
                    beat_cnt_d       = '0;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    busy_d           = 1'b1;
                    sel_d            = win_idx;
                end
            end
            LOCKED: begin
                if (release_pkt) begin
                    state_d    = IDLE;
                    ptr_d      = (owner_q == SEL_MAX) ? '0 : owner_q + SEL_WIDTH'(1);
                    beat_cnt_d = '0;
                    grant_d    = '0;
                    busy_d     = 1'b0;
                    sel_d      = '0;
                end else if (transfer && QUOTA_EN) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                beat_cnt_d = '0;
                grant_d    = '0;
                busy_d     = 1'b0;
                sel_d      = '0;
            end
        endcase
    end

    // State and output registers. Reset abandons any packet in flight and
    // returns the pointer to requester 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            sel_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            sel_q      <= sel_d;
        end
    end

    assign grant   = grant_q;
    assign busy    = busy_q;
    assign out_sel = sel_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter
// Self-checking bench for rr_mux_arbiter. A behavioural model of the
// arbitration rules predicts every output on every cycle. Directed
// scenarios cover the key behaviours, and a random phase follows them.

module tb_rr_mux_arbiter;

    localparam int N  = 8;
    localparam int W  = 32;
    localparam int SW = 3;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_last;
    logic [W-1:0]  req_data [0:N-1];
    logic [N-1:0]  req_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic [SW-1:0] out_sel;
    logic          out_ready;
    logic [N-1:0]  grant;
    logic          busy;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state: whether a packet holds the datapath, who owns
    // it, how many beats it has moved and where the next scan starts.
    bit m_locked = 1'b0;
    int m_owner  = 0;
    int m_beats  = 0;
    int m_ptr    = 0;

    // Observations of the DUT from the most recent cycle.
    bit dut_xfer;
    int dut_sel;
    bit dut_last;

    rr_mux_arbiter #(
        .N_REQ    (N),
        .WIDTH    (W),
        .SEL_WIDTH(SW),
        .MAX_BURST(MB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_last (req_last),
        .req_data (req_data),
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_last (out_last),
        .out_sel  (out_sel),
        .out_ready(out_ready),
        .grant    (grant),
        .busy     (busy)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Stop the run if the stimulus ever stalls.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    // Count one comparison and report it when the values differ.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Return the model to its power-on state.
    task automatic modelReset();
        m_locked = 1'b0;
        m_owner  = 0;
        m_beats  = 0;
        m_ptr    = 0;
    endtask

    // Run one clock cycle. Inputs are set at the falling edge by the caller.
    // Outputs are checked against the model, and the model then advances on
    // the rising edge.
    task automatic applyStimulus();
        logic [N-1:0] e_grant;
        logic [N-1:0] e_ready;
        logic         e_valid;
        logic         e_last;
        logic [W-1:0] e_data;
        bool_xfer: begin end
        #1;
        if (rst) modelReset();
        e_grant = '0;
        e_ready = '0;
        e_valid = 1'b0;
        e_last  = 1'b0;
        e_data  = '0;
        if (m_locked) begin
            e_grant[m_owner] = 1'b1;
            e_ready[m_owner] = out_ready;
            e_valid          = req_valid[m_owner];
            e_data           = req_data[m_owner];
            e_last           = req_last[m_owner] || (MB != 0 && m_beats + 1 == MB);
            checkOutput("out_sel", 64'(out_sel), 64'(m_owner));
        end
        checkOutput("grant", 64'(grant), 64'(e_grant));
        checkOutput("busy", 64'(busy), 64'(m_locked));
        checkOutput("req_ready", 64'(req_ready), 64'(e_ready));
        checkOutput("out_valid", 64'(out_valid), 64'(e_valid));
        checkOutput("out_data", 64'(out_data), 64'(e_data));
        checkOutput("out_last", 64'(out_last), 64'(e_last));
        dut_xfer = out_valid && out_ready;
        dut_sel  = int'(out_sel);
        dut_last = out_last;
        @(posedge clk);
        if (rst) begin
            modelReset();
        end else if (!m_locked) begin
            for (int off = 0; off < N; off++) begin
                if (!m_locked && req_valid[(m_ptr + off) % N]) begin
                    m_owner  = (m_ptr + off) % N;
                    m_locked = 1'b1;
                    m_beats  = 0;
                end
            end
        end else if (req_valid[m_owner] && out_ready) begin
            if (req_last[m_owner] || (MB != 0 && m_beats + 1 == MB)) begin
                m_locked = 1'b0;
                m_ptr    = (m_owner + 1) % N;
                m_beats  = 0;
            end else begin
                m_beats++;
            end
        end
        @(negedge clk);
    endtask

    // Clear all requester inputs.
    task automatic clearInputs();
        req_valid = '0;
        req_last  = '0;
        for (int i = 0; i < N; i++) req_data[i] = '0;
    endtask

    // Directed scenarios, then the random phase.
    initial begin
        int seq[$];
        int last_pos[$];
        int b;
        int cyc;
        bit pattern [4];

        clearInputs();
        out_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Values while reset is held.
        checkOutput("rst_grant", 64'(grant), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_ready", 64'(req_ready), 64'd0);
        checkOutput("rst_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_last", 64'(out_last), 64'd0);
        checkOutput("rst_data", 64'(out_data), 64'd0);
        checkOutput("rst_sel", 64'(out_sel), 64'd0);
        rst = 1'b0;

        // Quiet inputs after reset release.
        repeat (5) applyStimulus();

        // Everyone requests single-beat packets. Expect rotation 0..7,0 at one
        // beat per two cycles.
        req_valid = '1;
        req_last  = '1;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) req_data[i] = W'(i);
        cyc = 0;
        while (cyc < 40 && seq.size() < 9) begin
            applyStimulus();
            cyc++;
            if (dut_xfer) seq.push_back(dut_sel);
        end
        checkOutput("rr_count", 64'(seq.size()), 64'd9);
        checkOutput("rr_cycles", 64'(cyc), 64'd18);
        foreach (seq[i]) checkOutput("rr_order", 64'(seq[i]), 64'(i % N));
        clearInputs();
        applyStimulus();

        // Requester 3 sends a 4-beat packet while requester 5 waits.
        b = 0;
        cyc = 0;
        while (cyc < 20 && b < 4) begin
            req_valid   = 8'b0010_1000;
            req_data[3] = W'(32'h30 + b);
            req_last[3] = (b == 3);
            req_data[5] = W'(32'h55);
            req_last[5] = 1'b1;
            applyStimulus();
            cyc++;
            if (dut_xfer) begin
                checkOutput("lock_sel", 64'(dut_sel), 64'd3);
                b++;
            end
        end
        checkOutput("lock_beats", 64'(b), 64'd4);
        req_valid = 8'b0010_0000;
        applyStimulus();
        #1;
        checkOutput("next_owner", 64'(out_sel), 64'd5);
        applyStimulus();
        clearInputs();
        applyStimulus();

        // Requester 2 sends a 10-beat packet with a quota of 4 beats per grant.
        b = 0;
        cyc = 0;
        while (cyc < 40 && b < 10) begin
            req_valid   = 8'b0000_0100;
            req_data[2] = W'(32'h200 + b);
            req_last[2] = (b == 9);
            applyStimulus();
            cyc++;
            if (dut_xfer) begin
                b++;
                if (dut_last) last_pos.push_back(b);
            end
        end
        checkOutput("quota_beats", 64'(b), 64'd10);
        checkOutput("quota_cycles", 64'(cyc), 64'd13);
        checkOutput("quota_lasts", 64'(last_pos.size()), 64'd3);
        if (last_pos.size() == 3) begin
            checkOutput("quota_last0", 64'(last_pos[0]), 64'd4);
            checkOutput("quota_last1", 64'(last_pos[1]), 64'd8);
            checkOutput("quota_last2", 64'(last_pos[2]), 64'd10);
        end
        clearInputs();
        applyStimulus();

        // Requester 6 with out_ready stalling in a 1,0,0,1 pattern.
        pattern = '{1'b1, 1'b0, 1'b0, 1'b1};
        b = 0;
        cyc = 0;
        while (cyc < 30 && b < 4) begin
            req_valid   = 8'b0100_0000;
            req_data[6] = W'(32'h60 + b);
            req_last[6] = (b == 3);
            out_ready   = pattern[cyc % 4];
            applyStimulus();
            cyc++;
            if (dut_xfer) b++;
        end
        checkOutput("stall_beats", 64'(b), 64'd4);
        checkOutput("stall_cycles", 64'(cyc), 64'd9);
        clearInputs();
        out_ready = 1'b1;
        applyStimulus();

        // Requester 1 is reset asynchronously during its second beat.
        req_valid   = 8'b0000_0010;
        req_data[1] = W'(32'h10);
        applyStimulus();
        applyStimulus();
        req_data[1] = W'(32'h11);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_grant", 64'(grant), 64'd0);
        checkOutput("arst_busy", 64'(busy), 64'd0);
        checkOutput("arst_ready", 64'(req_ready), 64'd0);
        checkOutput("arst_valid", 64'(out_valid), 64'd0);
        modelReset();
        @(negedge clk);
        req_valid = 8'b1000_0011;
        applyStimulus();
        rst = 1'b0;
        applyStimulus();
        #1;
        checkOutput("post_rst_sel", 64'(out_sel), 64'd0);
        checkOutput("post_rst_grant", 64'(grant), 64'd1);
        @(negedge clk);
        modelReset();
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;

        // Random phase with occasional resets at cycle boundaries.
        for (int c = 0; c < 3000; c++) begin
            req_valid = N'($urandom & $urandom);
            req_last  = N'($urandom & $urandom);
            for (int i = 0; i < N; i++) req_data[i] = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 299) == 0);
            applyStimulus();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
